psec6_trigger_gen: RTL and testbench
====================================

// Module: psec6_trigger_gen
// PURPOSE
//  Self-trigger generator directly upstream of psec6_spi.trigger_in. Consumes discriminator hits plus the
//  SPI-configured mask/polarity/mode/delay, arms on inst_start, applies the coincidence rule, waits
//  trigger_delay cycles, then asserts trigger_out to stop sampling. Also latches the hit pattern and counts
//  fired triggers for readout.
// PARAMETERS
//  NCH       8   discriminator channels (matches 8-bit mask/polarity registers)
//  COINC_WIN 4   coincidence window length in clk cycles, range 1..15
//  CNT_W     16  width of trigger_count
// PORTS
//  clk                   in   1      sampling-domain clock
//  rst                   in   1      synchronous reset, active-high
//  disc_in               in   NCH    discriminator outputs, already synchronous to clk
//  disc_polarity         in   NCH    per-channel: 1 = active-low input (inverted before edge detect)
//  trigger_channel_mask  in   NCH    per-channel: 1 = channel may cause a trigger
//  mode                  in   2      00 ext only, 01 any-1, 10 at-least-2, 11 all enabled channels
//  trigger_delay         in   6      cycles from detection to trigger_out
//  ext_trig              in   1      external trigger; accepted in ARMED in every mode
//  inst_start            in   1      1-cycle pulse: arm (from instruction driver)
//  inst_rst              in   1      1-cycle pulse: return to IDLE, clear count
//  trigger_out           out  1      level; to psec6_spi.trigger_in
//  armed                 out  1      high while in ARMED
//  hit_pattern           out  NCH    channels participating in the accepted trigger
//  trig_src_ext          out  1      1 = accepted trigger came from ext_trig
//  trigger_count         out  CNT_W  number of fired triggers, saturating
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. Internal regs (disc_q, disc_qq, acc, win_cnt, dly_cnt) = 0.
//  Input stage: disc_q <= disc_in ^ disc_polarity; disc_qq <= disc_q, every cycle, in every state.
//    hit_vec = disc_q & ~disc_qq & trigger_channel_mask. Mask is used live.
//  States: IDLE, ARMED, DELAY, FIRED.
//  IDLE:  inst_start -> ARMED; acc, win_cnt cleared.
//  ARMED: cand = acc | hit_vec.
//    cond: 01 -> |cand; 10 -> popcount(cand) >= 2; 11 -> cand == mask with mask != 0; 00 -> never.
//    If ext_trig or cond -> DELAY. Load dly_cnt <= trigger_delay, which is sampled here.
//      hit_pattern <= cand. trig_src_ext <= ext_trig & ~cond.
//    Else if hit_vec != 0 and win_cnt == 0: acc <= hit_vec; win_cnt <= COINC_WIN-1.
//    Else if win_cnt != 0: acc <= acc | hit_vec; win_cnt decrements. At expiry, acc clears on the
//      next cycle. A new hit in the clearing cycle opens a new window.
//  DELAY: dly_cnt == 0 -> FIRED, else dly_cnt decrements.
//  FIRED: trigger_out = 1, registered. On entry, trigger_count increments, saturating at all-ones.
//    Stays in FIRED until inst_start (-> ARMED, trigger_out drops next cycle) or inst_rst.
//  Latency: disc_in goes active before edge k, and cond is met alone.
//    -> trigger_out is high from edge k+2+trigger_delay.
//    An ext_trig sampled high at edge k -> trigger_out high from edge k+2+trigger_delay.
//  inst_rst, in any state: -> IDLE next edge. Clears trigger_out, trigger_count, hit_pattern, acc.
//    Priority: rst > inst_rst > inst_start.
//  Ignored: inst_start in ARMED or DELAY. ext_trig and hits outside ARMED.
//  Simultaneous events: ext_trig and cond in the same cycle -> trig_src_ext = 0, hit_pattern = cand.
//  Mode 11 with mask == 0: can never self-trigger; only ext_trig fires.
//  Held input: a level held active produces exactly one hit (edge only).
//    Polarity change mid-run may create a spurious edge; this is accepted.
//  Register writes during DELAY: no effect on the current countdown.
// STRUCTURE
//  psec6_trig_pkg: trig_state_t enum {IDLE, ARMED, DELAY, FIRED}.
//    Mode constants MODE_EXT=2'b00, MODE_OR=2'b01, MODE_MAJ2=2'b10, MODE_AND=2'b11.
//  Sub-module trig_edge_detect: polarity XOR, two-stage register, masked rising-edge vector hit_vec.
//  Top: FSM, coincidence window/accumulator, delay counter, output registers, trigger_count.
// TESTING
//  1. mode=01, mask=8'h01, delay=5, arm, pulse disc_in[0] at edge k -> trigger_out from k+7.
//     Expect hit_pattern=8'h01 and trigger_count=1.
//  2. mode=10, COINC_WIN=4, hits ch2 at k and ch5 at k+3 -> fires, hit_pattern=8'h24.
//     Same hits with ch5 at k+4 -> no trigger, still armed.
//  3. mode=11, mask=8'h0F: ch0..ch3 within one window -> fire.
//     Ch3 masked off (mask=8'h07) mid-window: fires on ch0..ch2 only.
//  4. disc_polarity=8'hFF, disc_in idles 8'hFF, ch1 falls -> single hit.
//     Ch1 held low 100 cycles -> trigger_count stays 1 after re-arm.
//  5. mode=00 with channel hits -> nothing. ext_trig -> fires, trig_src_ext=1, hit_pattern=0.
//     inst_rst during DELAY -> IDLE, trigger_out never rises.
//  6. 65,540 arm/fire cycles (CNT_W=16) -> trigger_count saturates at 16'hFFFF.
//     inst_rst -> count = 0; inst_start+inst_rst in the same cycle -> IDLE.

Source files
------------

// File: rtl/psec6_trig_pkg.sv
// Shared types and constants for the psec6 self-trigger generator.
package psec6_trig_pkg;

  typedef enum logic [1:0] {StIdle, StArmed, StDelay, StFired} trig_state_t;

  localparam logic [1:0] ModeExt  = 2'b00;
  localparam logic [1:0] ModeOr   = 2'b01;
  localparam logic [1:0] ModeMaj2 = 2'b10;
  localparam logic [1:0] ModeAnd  = 2'b11;

  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  function automatic logic at_least_two(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/psec6_trig_edge_detect.sv
// Polarity-corrected two-stage input register and masked rising-edge detector.
module trig_edge_detect #(
  parameter int unsigned NCH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] disc_i,
  input  logic [NCH-1:0] polarity_i,
  input  logic [NCH-1:0] mask_i,
  output logic [NCH-1:0] hit_vec_o
);

  logic [NCH-1:0] disc_q, disc_d;
  logic [NCH-1:0] disc_qq, disc_qq_d;

  always_comb begin
    disc_d    = disc_i ^ polarity_i;
    disc_qq_d = disc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disc_q  <= '0;
      disc_qq <= '0;
    end else begin
      disc_q  <= disc_d;
      disc_qq <= disc_qq_d;
    end
  end

  assign hit_vec_o = disc_q & ~disc_qq & mask_i;

endmodule

// File: rtl/psec6_trigger_gen.sv
// Self-trigger generator: coincidence detection over a sliding window, programmable delay,
// registered trigger level, hit-pattern latch and saturating trigger counter.
module psec6_trigger_gen
  import psec6_trig_pkg::*;
#(
  parameter int unsigned NCH       = 8,
  parameter int unsigned COINC_WIN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   disc_in,
  input  logic [NCH-1:0]   disc_polarity,
  input  logic [NCH-1:0]   trigger_channel_mask,
  input  logic [1:0]       mode,
  input  logic [5:0]       trigger_delay,
  input  logic             ext_trig,
  input  logic             inst_start,
  input  logic             inst_rst,
  output logic             trigger_out,
  output logic             armed,
  output logic [NCH-1:0]   hit_pattern,
  output logic             trig_src_ext,
  output logic [CNT_W-1:0] trigger_count
);

  trig_state_t    state_q, state_d;
  logic [NCH-1:0] acc_q, acc_d;
  logic [3:0]     win_cnt_q, win_cnt_d;
  logic [5:0]     dly_cnt_q, dly_cnt_d;
  logic           ext_q, ext_d;
  logic           trigger_out_q, trigger_out_d;
  logic           armed_q, armed_d;
  logic [NCH-1:0] hit_pattern_q, hit_pattern_d;
  logic           trig_src_ext_q, trig_src_ext_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NCH-1:0] hit_vec;
  logic [NCH-1:0] cand;
  logic           cond;

  trig_edge_detect #(
    .NCH (NCH)
  ) u_edge (
    .clk_i      (clk),
    .rst_i      (rst),
    .disc_i     (disc_in),
    .polarity_i (disc_polarity),
    .mask_i     (trigger_channel_mask),
    .hit_vec_o  (hit_vec)
  );

  // A stale accumulator is ignored once its window has run out, so a hit in the
  // clearing cycle stands alone and opens a fresh window.
  assign cand = ((win_cnt_q != 4'd0) ? acc_q : '0) | hit_vec;

  always_comb begin
    unique case (mode)
      ModeOr:   cond = |cand;
      ModeMaj2: cond = at_least_two(32'(cand));
      ModeAnd:  cond = (cand == trigger_channel_mask) && (trigger_channel_mask != '0);
      ModeExt:  cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    win_cnt_d      = win_cnt_q;
    dly_cnt_d      = dly_cnt_q;
    ext_d          = ext_trig;
    trigger_out_d  = trigger_out_q;
    hit_pattern_d  = hit_pattern_q;
    trig_src_ext_d = trig_src_ext_q;
    count_d        = count_q;

    if (inst_rst) begin
      state_d       = StIdle;
      trigger_out_d = 1'b0;
      count_d       = '0;
      hit_pattern_d = '0;
      acc_d         = '0;
      win_cnt_d     = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inst_start) begin
            state_d   = StArmed;
            acc_d     = '0;
            win_cnt_d = 4'd0;
          end
        end
        StArmed: begin
          if (ext_q || cond) begin
            state_d        = StDelay;
            dly_cnt_d      = trigger_delay;
            hit_pattern_d  = cand;
            trig_src_ext_d = ext_q & ~cond;
            acc_d          = '0;
            win_cnt_d      = 4'd0;
          end else if ((hit_vec != '0) && (win_cnt_q == 4'd0)) begin
            acc_d     = hit_vec;
            win_cnt_d = 4'(COINC_WIN - 1);
          end else if (win_cnt_q != 4'd0) begin
            acc_d     = acc_q | hit_vec;
            win_cnt_d = win_cnt_q - 4'd1;
          end else begin
            acc_d = '0;
          end
        end
        StDelay: begin
          if (dly_cnt_q == 6'd0) begin
            state_d       = StFired;
            trigger_out_d = 1'b1;
            count_d       = (&count_q) ? count_q : count_q + 1'b1;
          end else begin
            dly_cnt_d = dly_cnt_q - 6'd1;
          end
        end
        StFired: begin
          if (inst_start) begin
            state_d       = StArmed;
            trigger_out_d = 1'b0;
            acc_d         = '0;
            win_cnt_d     = 4'd0;
          end
        end
      endcase
    end

    armed_d = (state_d == StArmed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      win_cnt_q      <= 4'd0;
      dly_cnt_q      <= 6'd0;
      ext_q          <= 1'b0;
      trigger_out_q  <= 1'b0;
      armed_q        <= 1'b0;
      hit_pattern_q  <= '0;
      trig_src_ext_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      win_cnt_q      <= win_cnt_d;
      dly_cnt_q      <= dly_cnt_d;
      ext_q          <= ext_d;
      trigger_out_q  <= trigger_out_d;
      armed_q        <= armed_d;
      hit_pattern_q  <= hit_pattern_d;
      trig_src_ext_q <= trig_src_ext_d;
      count_q        <= count_d;
    end
  end

  assign trigger_out   = trigger_out_q;
  assign armed         = armed_q;
  assign hit_pattern   = hit_pattern_q;
  assign trig_src_ext  = trig_src_ext_q;
  assign trigger_count = count_q;

endmodule

// File: tb/tb_psec6_trigger_gen.sv
// Directed bench for psec6_trigger_gen; a second, narrow-counter instance shares the stimulus.
module tb_psec6_trigger_gen;

  logic        clk;
  logic        rst;
  logic [7:0]  disc_in;
  logic [7:0]  disc_polarity;
  logic [7:0]  trigger_channel_mask;
  logic [1:0]  mode;
  logic [5:0]  trigger_delay;
  logic        ext_trig;
  logic        inst_start;
  logic        inst_rst;

  logic        trigger_out, armed, trig_src_ext;
  logic [7:0]  hit_pattern;
  logic [15:0] trigger_count;

  logic        s_trigger_out, s_armed, s_trig_src_ext;
  logic [7:0]  s_hit_pattern;
  logic [3:0]  s_trigger_count;

  int total = 0;
  int bad   = 0;

  psec6_trigger_gen #(
    .NCH       (8),
    .COINC_WIN (4),
    .CNT_W     (16)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .disc_in              (disc_in),
    .disc_polarity        (disc_polarity),
    .trigger_channel_mask (trigger_channel_mask),
    .mode                 (mode),
    .trigger_delay        (trigger_delay),
    .ext_trig             (ext_trig),
    .inst_start           (inst_start),
    .inst_rst             (inst_rst),
    .trigger_out          (trigger_out),
    .armed                (armed),
    .hit_pattern          (hit_pattern),
    .trig_src_ext         (trig_src_ext),
    .trigger_count        (trigger_count)
  );

  // Narrow counter so saturation is reachable in a short run.
  psec6_trigger_gen #(
    .NCH       (8),
    .COINC_WIN (4),
    .CNT_W     (4)
  ) u_dut_sat (
    .clk                  (clk),
    .rst                  (rst),
    .disc_in              (disc_in),
    .disc_polarity        (disc_polarity),
    .trigger_channel_mask (trigger_channel_mask),
    .mode                 (mode),
    .trigger_delay        (trigger_delay),
    .ext_trig             (ext_trig),
    .inst_start           (inst_start),
    .inst_rst             (inst_rst),
    .trigger_out          (s_trigger_out),
    .armed                (s_armed),
    .hit_pattern          (s_hit_pattern),
    .trig_src_ext         (s_trig_src_ext),
    .trigger_count        (s_trigger_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    inst_start = 1'b1;
    tick();
    inst_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    disc_in = 8'h00;
    disc_polarity = 8'h00;
    trigger_channel_mask = 8'h00;
    mode = 2'b00;
    trigger_delay = 6'd0;
    ext_trig = 1'b0;
    inst_start = 1'b0;
    inst_rst = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();
    check("rst_trigger_out", 32'(trigger_out), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_hit_pattern", 32'(hit_pattern), 32'd0);
    check("rst_trig_src_ext", 32'(trig_src_ext), 32'd0);
    check("rst_count", 32'(trigger_count), 32'd0);

    // 1: OR mode, single channel, delay 5 -> fires at k+7
    mode = 2'b01;
    trigger_channel_mask = 8'h01;
    trigger_delay = 6'd5;
    arm();
    check("t1_armed", 32'(armed), 32'd1);
    disc_in = 8'h01;
    tick();
    disc_in = 8'h00;
    ticks(6);
    check("t1_not_yet_k6", 32'(trigger_out), 32'd0);
    tick();
    check("t1_fire_k7", 32'(trigger_out), 32'd1);
    check("t1_pattern", 32'(hit_pattern), 32'h01);
    check("t1_count", 32'(trigger_count), 32'd1);
    check("t1_src_ext", 32'(trig_src_ext), 32'd0);
    check("t1_armed_low", 32'(armed), 32'd0);

    // 2: at-least-2 within the window, then one cycle too late
    mode = 2'b10;
    trigger_channel_mask = 8'hFF;
    trigger_delay = 6'd0;
    arm();
    check("t2_rearm_drop", 32'(trigger_out), 32'd0);
    check("t2_rearm_armed", 32'(armed), 32'd1);
    disc_in = 8'h04;
    tick();
    disc_in = 8'h00;
    ticks(2);
    disc_in = 8'h20;
    tick();
    disc_in = 8'h00;
    tick();
    check("t2_in_delay", 32'(armed), 32'd0);
    tick();
    check("t2_fire", 32'(trigger_out), 32'd1);
    check("t2_pattern", 32'(hit_pattern), 32'h24);
    check("t2_count", 32'(trigger_count), 32'd2);
    arm();
    disc_in = 8'h04;
    tick();
    disc_in = 8'h00;
    ticks(3);
    disc_in = 8'h20;
    tick();
    disc_in = 8'h00;
    ticks(4);
    check("t2_late_armed", 32'(armed), 32'd1);
    check("t2_late_no_trig", 32'(trigger_out), 32'd0);
    check("t2_late_count", 32'(trigger_count), 32'd2);

    // 3: all-enabled mode, then mask narrowed mid-window
    mode = 2'b11;
    trigger_channel_mask = 8'h0F;
    ticks(3);
    check("t3_no_spurious", 32'(armed), 32'd1);
    disc_in = 8'h01;
    tick();
    disc_in = 8'h02;
    tick();
    disc_in = 8'h04;
    tick();
    disc_in = 8'h08;
    tick();
    disc_in = 8'h00;
    tick();
    check("t3_and_delay", 32'(armed), 32'd0);
    tick();
    check("t3_and_fire", 32'(trigger_out), 32'd1);
    check("t3_and_pattern", 32'(hit_pattern), 32'h0F);
    arm();
    disc_in = 8'h01;
    tick();
    disc_in = 8'h02;
    tick();
    disc_in = 8'h00;
    trigger_channel_mask = 8'h07;
    tick();
    check("t3_partial_armed", 32'(armed), 32'd1);
    disc_in = 8'h04;
    tick();
    disc_in = 8'h00;
    tick();
    check("t3_mask_delay", 32'(armed), 32'd0);
    tick();
    check("t3_mask_fire", 32'(trigger_out), 32'd1);
    check("t3_mask_pattern", 32'(hit_pattern), 32'h07);
    check("t3_count", 32'(trigger_count), 32'd4);

    // 4: active-low inputs, falling ch1 is one hit; held low gives no more
    disc_polarity = 8'hFF;
    disc_in = 8'hFF;
    mode = 2'b01;
    trigger_channel_mask = 8'h02;
    ticks(2);
    arm();
    disc_in = 8'hFD;
    ticks(3);
    check("t4_fire", 32'(trigger_out), 32'd1);
    check("t4_pattern", 32'(hit_pattern), 32'h02);
    check("t4_count", 32'(trigger_count), 32'd5);
    arm();
    ticks(100);
    check("t4_held_armed", 32'(armed), 32'd1);
    check("t4_held_count", 32'(trigger_count), 32'd5);
    disc_in = 8'hFF;
    tick();
    disc_polarity = 8'h00;
    disc_in = 8'h00;
    ticks(2);

    // 5: ext-only mode ignores hits; ext_trig fires with k+2+delay latency
    mode = 2'b00;
    trigger_channel_mask = 8'hFF;
    trigger_delay = 6'd3;
    disc_in = 8'h0F;
    tick();
    disc_in = 8'h00;
    ticks(6);
    check("t5_hits_ignored", 32'(armed), 32'd1);
    check("t5_no_trig", 32'(trigger_out), 32'd0);
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    ticks(4);
    check("t5_ext_k4", 32'(trigger_out), 32'd0);
    tick();
    check("t5_ext_k5", 32'(trigger_out), 32'd1);
    check("t5_src_ext", 32'(trig_src_ext), 32'd1);
    check("t5_ext_pattern", 32'(hit_pattern), 32'h00);
    check("t5_count", 32'(trigger_count), 32'd6);
    arm();
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    tick();
    inst_rst = 1'b1;
    tick();
    inst_rst = 1'b0;
    check("t5_rst_armed", 32'(armed), 32'd0);
    check("t5_rst_count", 32'(trigger_count), 32'd0);
    check("t5_rst_pattern", 32'(hit_pattern), 32'h00);
    ticks(6);
    check("t5_rst_never_fires", 32'(trigger_out), 32'd0);

    // 6: repeated ext triggers saturate the narrow counter
    trigger_delay = 6'd0;
    ext_trig = 1'b1;
    for (int n = 0; n < 20; n++) begin
      arm();
      ticks(2);
    end
    ext_trig = 1'b0;
    check("t6_sat_count", 32'(s_trigger_count), 32'hF);
    check("t6_wide_count", 32'(trigger_count), 32'd20);
    check("t6_sat_fired", 32'(s_trigger_out), 32'd1);
    check("t6_sat_src_ext", 32'(s_trig_src_ext), 32'd1);
    inst_rst = 1'b1;
    tick();
    inst_rst = 1'b0;
    check("t6_rst_count", 32'(trigger_count), 32'd0);
    check("t6_rst_sat_count", 32'(s_trigger_count), 32'd0);
    check("t6_rst_trig", 32'(s_trigger_out), 32'd0);
    arm();
    check("t6_armed_again", 32'(armed), 32'd1);
    inst_start = 1'b1;
    inst_rst = 1'b1;
    tick();
    inst_start = 1'b0;
    inst_rst = 1'b0;
    check("t6_both_idle", 32'(armed), 32'd0);
    check("t6_both_sat_idle", 32'(s_armed), 32'd0);
    check("t6_both_trig", 32'(trigger_out), 32'd0);
    check("t6_both_pattern", 32'(s_hit_pattern), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
